// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared codes and types for the writeback unit
//
// Purpose: load-type and reg-dst encodings, FSM state enum and the fixed
// register numbers used by wb_writeback_unit and load_align.
// Ports: none (package).

package wb_pkg;

  // in_load_type encodings; 101..111 are illegal
  localparam logic [2:0] LT_LW  = 3'b000;
  localparam logic [2:0] LT_LH  = 3'b001;
  localparam logic [2:0] LT_LHU = 3'b010;
  localparam logic [2:0] LT_LB  = 3'b011;
  localparam logic [2:0] LT_LBU = 3'b100;

  // in_reg_dst encodings
  localparam logic [1:0] RD_RT      = 2'b00;
  localparam logic [1:0] RD_RD      = 2'b01;
  localparam logic [1:0] RD_LINK    = 2'b10;
  localparam logic [1:0] RD_ILLEGAL = 2'b11;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_RA   = 5'd31;

  typedef enum logic [0:0] {
    S_IDLE     = 1'b0,
    S_WAIT_MEM = 1'b1
  } wb_state_t;

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - big-endian load data extraction and alignment check
//
// Purpose: selects the addressed byte/halfword/word of a big-endian memory
// word, sign- or zero-extends it, and flags misaligned or unknown loads.
// Ports:
//   i_rdata     in  32  memory word (byte 0 = bits 31:24)
//   i_offset    in  2   byte offset within the word
//   i_load_type in  3   load type code (wb_pkg LT_*)
//   o_data      out 32  aligned, extended result
//   o_bad       out 1   misaligned access or illegal load type

module load_align
  import wb_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_offset,
  input  logic [2:0]  i_load_type,
  output logic [31:0] o_data,
  output logic        o_bad
);

  logic [15:0] w_half;
  logic [7:0]  w_byte;

  always_comb begin
    w_half = i_offset[1] ? i_rdata[15:0] : i_rdata[31:16];
    case (i_offset)
      2'd0:    w_byte = i_rdata[31:24];
      2'd1:    w_byte = i_rdata[23:16];
      2'd2:    w_byte = i_rdata[15:8];
      default: w_byte = i_rdata[7:0];
    endcase
  end

  always_comb begin
    o_data = 32'h0;
    o_bad  = 1'b0;
    case (i_load_type)
      LT_LW: begin
        o_data = i_rdata;
        o_bad  = (i_offset != 2'b00);
      end
      LT_LH: begin
        o_data = {{16{w_half[15]}}, w_half};
        o_bad  = i_offset[0];
      end
      LT_LHU: begin
        o_data = {16'h0, w_half};
        o_bad  = i_offset[0];
      end
      LT_LB:  o_data = {{24{w_byte[7]}}, w_byte};
      LT_LBU: o_data = {24'h0, w_byte};
      default: o_bad = 1'b1;
    endcase
  end

endmodule

// File: rtl/wb_writeback_unit.sv
// rtl/wb_writeback_unit.sv - writeback stage driving the register-file write port
//
// Purpose: retires one instruction per handshake. ALU/link results are
// written one cycle after acceptance; loads wait for the memory response,
// are aligned by load_align and then written. Writes to $0 are suppressed
// when ZERO_GUARD is set; illegal, misaligned or timed-out loads pulse err.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid / in_ready      MEM-stage handshake
//   in_reg_write, in_reg_dst, in_rt, in_rd     destination selection
//   in_mem_to_reg, in_load_type                result source / load kind
//   in_alu_result, in_pc_plus4                 ALU/address and link value
//   mem_rvalid, mem_rdata    load response (single-cycle pulse)
//   rf_wr_en/addr/data       registered register-file write port
//   busy                     waiting on memory
//   err                      one-cycle error pulse

module wb_writeback_unit
  import wb_pkg::*;
#(
  parameter int TIMEOUT    = 16,
  parameter int ZERO_GUARD = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_reg_write,
  input  logic [1:0]  in_reg_dst,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic        in_mem_to_reg,
  input  logic [2:0]  in_load_type,
  input  logic [31:0] in_alu_result,
  input  logic [31:0] in_pc_plus4,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        rf_wr_en,
  output logic [4:0]  rf_wr_addr,
  output logic [31:0] rf_wr_data,
  output logic        busy,
  output logic        err
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam bit GUARD = (ZERO_GUARD != 0);

  wb_state_t        r_state;
  wb_state_t        w_state_nx;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nx;

  // Load context captured at acceptance
  logic [4:0]  r_dst_addr;
  logic        r_dst_ok;
  logic [2:0]  r_load_type;
  logic [1:0]  r_offset;
  logic        w_capture;

  logic        r_wr_en;
  logic [4:0]  r_wr_addr;
  logic [31:0] r_wr_data;
  logic        r_err;
  logic        w_wr_en_nx;
  logic [4:0]  w_wr_addr_nx;
  logic [31:0] w_wr_data_nx;
  logic        w_err_nx;

  logic [4:0]  w_dst_addr;
  logic        w_dst_ok;
  logic [31:0] w_alu_data;

  logic [31:0] w_al_rdata;
  logic [1:0]  w_al_offset;
  logic [2:0]  w_al_type;
  logic [31:0] w_al_data;
  logic        w_al_bad;

  // Destination decode for the instruction currently presented
  always_comb begin
    case (in_reg_dst)
      RD_RT:   w_dst_addr = in_rt;
      RD_RD:   w_dst_addr = in_rd;
      RD_LINK: w_dst_addr = REG_RA;
      default: w_dst_addr = REG_ZERO;
    endcase
    w_dst_ok   = in_reg_write && (in_reg_dst != RD_ILLEGAL) &&
                 !(GUARD && (w_dst_addr == REG_ZERO));
    w_alu_data = (in_reg_dst == RD_LINK) ? in_pc_plus4 : in_alu_result;
  end

  // One aligner serves both jobs: in IDLE it checks the incoming load's
  // type/offset against dummy data; in WAIT_MEM it aligns the response
  // using the captured type/offset.
  always_comb begin
    if (r_state == S_WAIT_MEM) begin
      w_al_rdata  = mem_rdata;
      w_al_offset = r_offset;
      w_al_type   = r_load_type;
    end else begin
      w_al_rdata  = 32'h0;
      w_al_offset = in_alu_result[1:0];
      w_al_type   = in_load_type;
    end
  end

  load_align u_align (
    .i_rdata     (w_al_rdata),
    .i_offset    (w_al_offset),
    .i_load_type (w_al_type),
    .o_data      (w_al_data),
    .o_bad       (w_al_bad)
  );

  // Next-state and next-output logic
  always_comb begin
    w_state_nx   = r_state;
    w_cnt_nx     = r_cnt;
    w_capture    = 1'b0;
    w_wr_en_nx   = 1'b0;
    w_wr_addr_nx = r_wr_addr;
    w_wr_data_nx = r_wr_data;
    w_err_nx     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          if (!in_mem_to_reg) begin
            if (w_dst_ok) begin
              w_wr_en_nx   = 1'b1;
              w_wr_addr_nx = w_dst_addr;
              w_wr_data_nx = w_alu_data;
            end
          end else if (w_al_bad) begin
            w_err_nx = 1'b1;
          end else begin
            w_state_nx = S_WAIT_MEM;
            w_cnt_nx   = '0;
            w_capture  = 1'b1;
          end
        end
      end
      S_WAIT_MEM: begin
        if (mem_rvalid) begin
          w_state_nx = S_IDLE;
          if (r_dst_ok) begin
            w_wr_en_nx   = 1'b1;
            w_wr_addr_nx = r_dst_addr;
            w_wr_data_nx = w_al_data;
          end
        end else if (r_cnt == CNT_LAST) begin
          w_state_nx = S_IDLE;
          w_err_nx   = 1'b1;
        end else begin
          w_cnt_nx = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_dst_addr  <= REG_ZERO;
      r_dst_ok    <= 1'b0;
      r_load_type <= LT_LW;
      r_offset    <= 2'b00;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= REG_ZERO;
      r_wr_data   <= 32'h0;
      r_err       <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_cnt     <= w_cnt_nx;
      r_wr_en   <= w_wr_en_nx;
      r_wr_addr <= w_wr_addr_nx;
      r_wr_data <= w_wr_data_nx;
      r_err     <= w_err_nx;
      if (w_capture) begin
        r_dst_addr  <= w_dst_addr;
        r_dst_ok    <= w_dst_ok;
        r_load_type <= in_load_type;
        r_offset    <= in_alu_result[1:0];
      end
    end
  end

  assign in_ready   = (r_state == S_IDLE);
  assign busy       = (r_state == S_WAIT_MEM);
  assign rf_wr_en   = r_wr_en;
  assign rf_wr_addr = r_wr_addr;
  assign rf_wr_data = r_wr_data;
  assign err        = r_err;

endmodule

// File: tb/tb_wb_writeback_unit.sv
// tb/tb_wb_writeback_unit.sv - self-checking bench for wb_writeback_unit

module tb_wb_writeback_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_reg_write;
  logic [1:0]  in_reg_dst;
  logic [4:0]  in_rt;
  logic [4:0]  in_rd;
  logic        in_mem_to_reg;
  logic [2:0]  in_load_type;
  logic [31:0] in_alu_result;
  logic [31:0] in_pc_plus4;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        rf_wr_en;
  logic [4:0]  rf_wr_addr;
  logic [31:0] rf_wr_data;
  logic        busy;
  logic        err;

  int n_cmp = 0;
  int n_err = 0;

  // last written address/data as the register file would see them
  logic [4:0]  m_addr;
  logic [31:0] m_data;

  always #5 clk = ~clk;

  wb_writeback_unit #(.TIMEOUT(16), .ZERO_GUARD(1)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_reg_write  (in_reg_write),
    .in_reg_dst    (in_reg_dst),
    .in_rt         (in_rt),
    .in_rd         (in_rd),
    .in_mem_to_reg (in_mem_to_reg),
    .in_load_type  (in_load_type),
    .in_alu_result (in_alu_result),
    .in_pc_plus4   (in_pc_plus4),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata),
    .rf_wr_en      (rf_wr_en),
    .rf_wr_addr    (rf_wr_addr),
    .rf_wr_data    (rf_wr_data),
    .busy          (busy),
    .err           (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // advance one clock; outputs are sampled and inputs changed 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [4:0] ref_dest(input logic [1:0] dst, input logic [4:0] rt,
                                          input logic [4:0] rd);
    if (dst == 2'd0) return rt;
    if (dst == 2'd1) return rd;
    if (dst == 2'd2) return 5'd31;
    return 5'd0;
  endfunction

  function automatic bit ref_writes(input bit rw, input logic [1:0] dst, input logic [4:0] a);
    return rw && (dst != 2'd3) && (a != 5'd0);
  endfunction

  function automatic int ref_size(input int t);
    if (t == 0) return 4;
    if (t == 1 || t == 2) return 2;
    return 1;
  endfunction

  function automatic bit ref_legal(input int t, input int off);
    if (t > 4) return 1'b0;
    return (off % ref_size(t)) == 0;
  endfunction

  // big-endian: the access covers bytes off..off+size-1 of the word
  function automatic logic [31:0] ref_load(input int t, input int off, input logic [31:0] w);
    int sz;
    logic [31:0] v, mask;
    sz   = ref_size(t);
    v    = w >> (8 * (4 - off - sz));
    mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * sz)) - 32'h1);
    v    = v & mask;
    if ((t == 1 || t == 3) && v[8*sz-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic expect_write(input string tag, input bit en);
    chk({tag, ".en"}, {31'h0, rf_wr_en}, {31'h0, en});
    chk({tag, ".addr"}, {27'h0, rf_wr_addr}, {27'h0, m_addr});
    chk({tag, ".data"}, rf_wr_data, m_data);
  endtask

  task automatic do_alu(input string tag, input bit rw, input logic [1:0] dst,
                        input logic [4:0] rt, input logic [4:0] rd,
                        input logic [31:0] alu, input logic [31:0] pc);
    logic [4:0] a;
    bit w;
    in_valid = 1'b1; in_mem_to_reg = 1'b0; in_reg_write = rw; in_reg_dst = dst;
    in_rt = rt; in_rd = rd; in_alu_result = alu; in_pc_plus4 = pc;
    in_load_type = 3'($urandom_range(0, 7));
    step();
    in_valid = 1'b0;
    a = ref_dest(dst, rt, rd);
    w = ref_writes(rw, dst, a);
    if (w) begin
      m_addr = a;
      m_data = (dst == 2'd2) ? pc : alu;
    end
    expect_write(tag, w);
    chk({tag, ".err"}, {31'h0, err}, 32'h0);
    chk({tag, ".rdy"}, {31'h0, in_ready}, 32'h1);
  endtask

  task automatic do_load(input string tag, input bit rw, input logic [2:0] lt,
                         input logic [1:0] dst, input logic [4:0] rt, input logic [4:0] rd,
                         input logic [31:0] addr, input logic [31:0] rdata, input int delay);
    logic [4:0] a;
    bit w;
    in_valid = 1'b1; in_mem_to_reg = 1'b1; in_reg_write = rw; in_reg_dst = dst;
    in_rt = rt; in_rd = rd; in_alu_result = addr; in_load_type = lt;
    in_pc_plus4 = $urandom;
    step();
    in_valid = 1'b0;
    chk({tag, ".acc_en"}, {31'h0, rf_wr_en}, 32'h0);
    if (!ref_legal(int'(lt), int'(addr[1:0]))) begin
      chk({tag, ".bad_err"}, {31'h0, err}, 32'h1);
      chk({tag, ".bad_rdy"}, {31'h0, in_ready}, 32'h1);
      chk({tag, ".bad_busy"}, {31'h0, busy}, 32'h0);
      step();
      chk({tag, ".bad_err_end"}, {31'h0, err}, 32'h0);
      return;
    end
    chk({tag, ".busy"}, {31'h0, busy}, 32'h1);
    chk({tag, ".rdy"}, {31'h0, in_ready}, 32'h0);
    for (int i = 0; i < delay; i++) begin
      mem_rdata = $urandom;
      step();
      chk({tag, ".wait_busy"}, {31'h0, busy}, 32'h1);
      chk({tag, ".wait_en"}, {31'h0, rf_wr_en}, 32'h0);
    end
    mem_rvalid = 1'b1; mem_rdata = rdata;
    step();
    mem_rvalid = 1'b0;
    a = ref_dest(dst, rt, rd);
    w = ref_writes(rw, dst, a);
    if (w) begin
      m_addr = a;
      m_data = ref_load(int'(lt), int'(addr[1:0]), rdata);
    end
    expect_write(tag, w);
    chk({tag, ".done_busy"}, {31'h0, busy}, 32'h0);
    chk({tag, ".done_rdy"}, {31'h0, in_ready}, 32'h1);
    chk({tag, ".done_err"}, {31'h0, err}, 32'h0);
  endtask

  initial begin
    logic [31:0] r_addr;
    rst = 1'b1; in_valid = 1'b0; in_reg_write = 1'b0; in_reg_dst = 2'd0;
    in_rt = 5'd0; in_rd = 5'd0; in_mem_to_reg = 1'b0; in_load_type = 3'd0;
    in_alu_result = 32'h0; in_pc_plus4 = 32'h0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    m_addr = 5'd0; m_data = 32'h0;
    step(); step();
    rst = 1'b0;

    // reset state
    expect_write("reset", 1'b0);
    chk("reset.err", {31'h0, err}, 32'h0);
    chk("reset.busy", {31'h0, busy}, 32'h0);
    chk("reset.rdy", {31'h0, in_ready}, 32'h1);

    // directed ALU / link cases
    do_alu("alu_rd8", 1'b1, 2'd1, 5'd3, 5'd8, 32'h0000_1234, 32'h0);
    do_alu("link", 1'b1, 2'd2, 5'd5, 5'd6, 32'hDEAD_0000, 32'h0040_0010);
    do_alu("rt_zero", 1'b1, 2'd0, 5'd0, 5'd9, 32'h0040_0010, 32'h0040_0010);
    do_alu("dst_ill", 1'b1, 2'd3, 5'd4, 5'd9, 32'h5555_5555, 32'h0);
    do_alu("no_rw", 1'b0, 2'd1, 5'd4, 5'd9, 32'h6666_6666, 32'h0);

    // directed loads
    do_load("lb", 1'b1, 3'd3, 2'd0, 5'd10, 5'd0, 32'h1000_0001, 32'h1185_2233, 2);
    do_load("lbu", 1'b1, 3'd4, 2'd0, 5'd11, 5'd0, 32'h1000_0001, 32'h1185_2233, 2);
    do_load("lh", 1'b1, 3'd1, 2'd1, 5'd0, 5'd12, 32'h2000_0002, 32'hAAAA_8001, 0);
    do_load("lhu", 1'b1, 3'd2, 2'd1, 5'd0, 5'd13, 32'h2000_0002, 32'hAAAA_8001, 1);
    do_load("lw_mis", 1'b1, 3'd0, 2'd0, 5'd14, 5'd0, 32'h3000_0002, 32'h0, 0);
    do_load("ill_type", 1'b1, 3'd6, 2'd0, 5'd14, 5'd0, 32'h3000_0000, 32'h0, 0);
    do_load("lw_r0", 1'b1, 3'd0, 2'd0, 5'd0, 5'd0, 32'h3000_0000, 32'hCAFE_BABE, 3);

    // timeout: 16 cycles in WAIT_MEM without a response
    in_valid = 1'b1; in_mem_to_reg = 1'b1; in_reg_write = 1'b1; in_reg_dst = 2'd0;
    in_rt = 5'd20; in_load_type = 3'd0; in_alu_result = 32'h4000_0000;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      chk("to.busy", {31'h0, busy}, 32'h1);
      chk("to.err_early", {31'h0, err}, 32'h0);
    end
    step();
    chk("to.err", {31'h0, err}, 32'h1);
    chk("to.idle", {31'h0, busy}, 32'h0);
    chk("to.rdy", {31'h0, in_ready}, 32'h1);
    expect_write("to", 1'b0);
    step();
    chk("to.err_pulse", {31'h0, err}, 32'h0);

    // reset in the middle of WAIT_MEM, with a response arriving alongside
    in_valid = 1'b1; in_mem_to_reg = 1'b1; in_reg_write = 1'b1; in_reg_dst = 2'd0;
    in_rt = 5'd21; in_load_type = 3'd0; in_alu_result = 32'h4000_0000;
    step();
    in_valid = 1'b0;
    step(); step();
    rst = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    step();
    rst = 1'b0; mem_rvalid = 1'b0;
    m_addr = 5'd0; m_data = 32'h0;
    expect_write("rst_wait", 1'b0);
    chk("rst_wait.busy", {31'h0, busy}, 32'h0);
    chk("rst_wait.rdy", {31'h0, in_ready}, 32'h1);
    chk("rst_wait.err", {31'h0, err}, 32'h0);
    step();
    expect_write("rst_wait2", 1'b0);

    // four back-to-back ALU writes to r1..r4
    for (int i = 1; i <= 4; i++) begin
      r_addr = $urandom;
      do_alu("b2b", 1'b1, 2'd1, 5'd0, 5'(i), r_addr, 32'h0);
    end
    step();
    chk("b2b.end_en", {31'h0, rf_wr_en}, 32'h0);

    // stray response while idle
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    step();
    mem_rvalid = 1'b0;
    expect_write("idle_rvalid", 1'b0);
    chk("idle_rvalid.busy", {31'h0, busy}, 32'h0);

    // randomized mix
    for (int k = 0; k < 60; k++) begin
      r_addr = $urandom;
      if ($urandom_range(0, 2) == 0)
        do_alu("rnd_alu", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
               5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), r_addr, $urandom);
      else
        do_load("rnd_ld", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
                5'($urandom_range(0, 31)), r_addr, $urandom, $urandom_range(0, 6));
      if ($urandom_range(0, 3) == 0) begin
        step();
        chk("rnd_gap_en", {31'h0, rf_wr_en}, 32'h0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wb_writeback_unit.md
Name: wb_writeback_unit

Overview:
- Writeback stage that drives the register file's write port: destination register select, write-enable and 32-bit write data.
- Takes one retiring instruction per handshake from the MEM stage.
- For loads, waits for the data-memory response, then extracts, aligns and extends the requested bytes.
- Suppresses writes to $0 and reports illegal or misaligned loads.

Parameters:
- TIMEOUT, 16: max cycles spent in WAIT_MEM before abandoning the load.
- ZERO_GUARD, 1: when 1, writes addressed to register 0 are suppressed.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  MEM stage presents an instruction
- in_ready  out  1  unit can accept; transfer occurs when in_valid && in_ready
- in_reg_write  in  1  instruction writes a register
- in_reg_dst  in  2  00 = rt, 01 = rd, 10 = $31 (link), 11 = illegal
- in_rt  in  5  rt field
- in_rd  in  5  rd field
- in_mem_to_reg  in  1  1 = load result, 0 = ALU/link result
- in_load_type  in  3  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU
- in_alu_result  in  32  ALU result; effective address for loads
- in_pc_plus4  in  32  link value used when in_reg_dst = 10
- mem_rvalid  in  1  load data valid, single-cycle pulse
- mem_rdata  in  32  load word, big-endian (byte 0 = bits 31:24)
- rf_wr_en  out  1  register-file write strobe
- rf_wr_addr  out  5  destination register
- rf_wr_data  out  32  write data
- busy  out  1  high in WAIT_MEM
- err  out  1  one-cycle pulse on illegal, misaligned or timed-out load

Behaviour:
- Reset: state = IDLE. rf_wr_en = 0, rf_wr_addr = 0, rf_wr_data = 0, err = 0, busy = 0, in_ready = 1, timeout counter = 0. A reset during WAIT_MEM abandons the load with no write.
- States: IDLE, WAIT_MEM. All rf_wr_* and err outputs are registered.
- in_ready = 1 in IDLE, 0 in WAIT_MEM.
- Accept in IDLE with in_mem_to_reg = 0:
  - Next cycle, rf_wr_en = in_reg_write && !(ZERO_GUARD && addr == 0) && in_reg_dst != 11.
  - addr is chosen by in_reg_dst. Data = in_pc_plus4 when in_reg_dst = 10, otherwise in_alu_result.
  - Latency 1; back-to-back accepts sustain one write per cycle.
- Accept with in_mem_to_reg = 1:
  - Capture destination, load_type and offset = in_alu_result[1:0]; go to WAIT_MEM and clear the counter.
  - The acceptance cycle produces no write (rf_wr_en = 0 next cycle).
- WAIT_MEM:
  - On mem_rvalid, align the data; the next cycle rf_wr_en = 1 (subject to the $0 guard and reg_write) with the aligned data. Return to IDLE in that same transition.
  - in_ready goes to 1 the cycle after mem_rvalid.
  - Otherwise the counter increments. When it reaches TIMEOUT-1 without rvalid: go to IDLE, no write, err pulse next cycle.
- Alignment (big-endian):
  - LW: offset must be 00.
  - LH/LHU: offset[0] must be 0. Halfword 0 = bits 31:16, halfword 2 = bits 15:0.
  - LB/LBU: byte n = bits (31-8n):(24-8n).
  - LH/LB sign-extend; LHU/LBU zero-extend.
- Misaligned access or load_type 101–111: detected at acceptance. No write, err pulse next cycle, and the unit stays in IDLE (does not wait for memory).
- mem_rvalid in IDLE is ignored.
- rf_wr_en is deasserted in every cycle not described above. rf_wr_addr and rf_wr_data hold their last values when rf_wr_en = 0.

Decomposition:
- Package wb_pkg: load_type codes, reg_dst codes, the state enum, the REG_ZERO and REG_RA (31) constants.
- Sub-module load_align (combinational): inputs mem_rdata, offset, load_type; outputs aligned 32-bit data and a misaligned/illegal flag. It is reused by the acceptance check with a dummy data input.

Test Plan:
- ALU op, reg_dst = 01, rd = 8, alu_result = 0x0000_1234 -> next cycle rf_wr_en = 1, addr = 8, data = 0x0000_1234; in_ready stays 1.
- Link, reg_dst = 10, pc_plus4 = 0x0040_0010 -> addr = 31, data = 0x0040_0010. Same op with rt = 0, reg_dst = 00 -> rf_wr_en = 0.
- LB, offset 01, mem_rdata = 0x1185_2233 three cycles after accept -> busy = 1 and in_ready = 0 while waiting; write data = 0xFFFF_FF85. LBU with the same data -> 0x0000_0085.
- LH, offset 10, rdata = 0xAAAA_8001 -> 0xFFFF_8001. LHU -> 0x0000_8001. LW with offset 10 -> err pulse, no write, in_ready stays 1.
- Load with no mem_rvalid for TIMEOUT = 16 cycles -> err pulse, no write, back in IDLE. rst asserted mid-WAIT_MEM -> no write, all outputs at reset values.
- Four back-to-back ALU ops to r1..r4 -> four consecutive write cycles, no bubbles; mem_rvalid pulse in IDLE causes no write.
